// File: rtl/stage_combine_pkg.sv
// Shared types and defaults for the stage_combine_sync elastic pipeline stage.
package stage_combine_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/stage_combine_sync_if.sv
// Valid/ack handshake bundle for stage_combine_sync: upstream (producer) and downstream (consumer).
interface stage_combine_sync_if
    import stage_combine_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  ack_out;
    logic                  valid_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  ack_in;

    // master drives beats in and consumes beats out; slave is the stage itself
    modport master (
        output valid_in, data_in, ack_in,
        input  ack_out, valid_out, data_out
    );

    modport slave (
        input  valid_in, data_in, ack_in,
        output ack_out, valid_out, data_out
    );

endinterface

// File: rtl/stage_combine_sync.sv
// Two-entry elastic stage (main + skid) with registered ack_out, synchronous active-high reset.
// Define STAGE_COMBINE_BYPASS_EN for zero-latency pass-through while the stage is empty.
module stage_combine_sync
    import stage_combine_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input logic                 clk,
    input logic                 rst,
    stage_combine_sync_if.slave bus
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  ack_q, ack_d;

    logic                  in_xfer;
    logic                  out_xfer;
    logic                  valid_out;
    logic [DATA_WIDTH-1:0] data_out;

    assign in_xfer = bus.valid_in & ack_q;

`ifdef STAGE_COMBINE_BYPASS_EN
    // While empty the incoming beat is presented straight to the consumer.
    always_comb begin
        if (state_q == ST_EMPTY) begin
            valid_out = in_xfer;
            data_out  = bus.data_in;
        end else begin
            valid_out = 1'b1;
            data_out  = main_q;
        end
    end
`else
    always_comb begin
        valid_out = (state_q != ST_EMPTY);
        data_out  = main_q;
    end
`endif

    assign out_xfer      = valid_out & bus.ack_in;
    assign bus.valid_out = valid_out;
    assign bus.data_out  = data_out;
    assign bus.ack_out   = ack_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
`ifdef STAGE_COMBINE_BYPASS_EN
                // A beat consumed in the same cycle is never stored.
                if (in_xfer && !bus.ack_in) begin
                    state_d = ST_ONE;
                    main_d  = bus.data_in;
                end
`else
                if (in_xfer) begin
                    state_d = ST_ONE;
                    main_d  = bus.data_in;
                end
`endif
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = bus.data_in;
                end else if (in_xfer) begin
                    state_d = ST_FULL;
                    skid_d  = bus.data_in;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // ack_out is registered, so it reflects whether the next state has a free slot.
        ack_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ack_q   <= ack_d;
        end
    end

endmodule

// File: tb/tb_stage_combine_sync.sv
// Self-checking bench for stage_combine_sync against a queue-based model of a two-beat buffer.
module tb_stage_combine_sync;

    localparam int unsigned W = stage_combine_pkg::DEFAULT_DATA_WIDTH;
`ifdef STAGE_COMBINE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    stage_combine_sync_if #(.DATA_WIDTH(W)) bus ();

    stage_combine_sync #(.DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: beats held by the stage, oldest first; ack_en is low until the first non-reset edge.
    logic [W-1:0] q[$];
    bit           ack_en = 1'b0;

    function automatic bit m_ack();
        return ack_en && (q.size() < 2);
    endfunction

    function automatic bit m_valid();
        return (q.size() > 0) || (BYPASS && ack_en && bus.valid_in);
    endfunction

    function automatic logic [W-1:0] m_data();
        return (q.size() > 0) ? q[0] : bus.data_in;
    endfunction

    task automatic drive(input bit v, input logic [W-1:0] d, input bit a);
        @(negedge clk);
        bus.valid_in = v;
        bus.data_in  = d;
        bus.ack_in   = a;
        #1;
    endtask

    task automatic step();
        bit in_x, out_x, pass;
        logic [W-1:0] d;
        in_x  = bus.valid_in && m_ack();
        out_x = m_valid() && bus.ack_in;
        pass  = BYPASS && (q.size() == 0) && in_x && bus.ack_in;
        d     = bus.data_in;
        @(posedge clk);
        if (rst) begin
            q.delete();
            ack_en = 1'b0;
        end else begin
            if (out_x && q.size() > 0) void'(q.pop_front());
            if (in_x && !pass) q.push_back(d);
            ack_en = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 3'd5, 1'b1);
        step();
        drive(1'b1, 3'd5, 1'b1);
        step();
        drive(1'b0, 3'd0, 1'b0);
        total += 3;
        if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.valid_out); end
        if (bus.data_out !== '0) begin bad++; $display("FAIL reset_data got=%0d want=0", bus.data_out); end
        if (bus.ack_out !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", bus.ack_out); end
        rst = 1'b0;
        step();
        drive(1'b0, 3'd0, 1'b0);
        total += 2;
        if (bus.ack_out !== 1'b1) begin bad++; $display("FAIL reset_ack_rise got=%b want=1", bus.ack_out); end
        if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL reset_idle_valid got=%b want=0", bus.valid_out); end
    endtask

    task automatic test_stall();
        drive(1'b1, 3'd1, 1'b0);
        step();
        drive(1'b1, 3'd2, 1'b0);
        total += 3;
        if (bus.valid_out !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b want=1", bus.valid_out); end
        if (bus.data_out !== 3'd1) begin bad++; $display("FAIL stall_data got=%0d want=1", bus.data_out); end
        if (bus.ack_out !== 1'b1) begin bad++; $display("FAIL stall_ack_one got=%b want=1", bus.ack_out); end
        step();
        drive(1'b0, 3'd0, 1'b0);
        total += 3;
        if (bus.ack_out !== 1'b0) begin bad++; $display("FAIL stall_full_ack got=%b want=0", bus.ack_out); end
        if (bus.valid_out !== 1'b1) begin bad++; $display("FAIL stall_full_valid got=%b want=1", bus.valid_out); end
        if (bus.data_out !== 3'd1) begin bad++; $display("FAIL stall_full_data got=%0d want=1", bus.data_out); end
        step();
    endtask

    task automatic test_drain();
        logic [W-1:0] want[2] = '{3'd1, 3'd2};
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 3'd0, 1'b1);
            total += 3;
            if (bus.valid_out !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d] got=%b want=1", i, bus.valid_out); end
            if (bus.data_out !== want[i]) begin bad++; $display("FAIL drain_data[%0d] got=%0d want=%0d", i, bus.data_out, want[i]); end
            if (bus.ack_out !== (i == 1)) begin bad++; $display("FAIL drain_ack[%0d] got=%b want=%b", i, bus.ack_out, i == 1); end
            step();
        end
        drive(1'b0, 3'd0, 1'b0);
        total += 2;
        if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL drain_empty_valid got=%b want=0", bus.valid_out); end
        if (bus.ack_out !== 1'b1) begin bad++; $display("FAIL drain_empty_ack got=%b want=1", bus.ack_out); end
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 5; i++) begin
            drive(i <= 4, W'(i), 1'b1);
            total += 3;
            if (bus.ack_out !== 1'b1) begin bad++; $display("FAIL stream_ack[%0d] got=%b want=1", i, bus.ack_out); end
            if (bus.valid_out !== m_valid()) begin bad++; $display("FAIL stream_valid[%0d] got=%b want=%b", i, bus.valid_out, m_valid()); end
            if (m_valid() && bus.data_out !== m_data()) begin bad++; $display("FAIL stream_data[%0d] got=%0d want=%0d", i, bus.data_out, m_data()); end
            step();
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, (i % 2 == 0) ? 3'd3 : 3'd4, 1'b0);
            total += 2;
            if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL idle_valid[%0d] got=%b want=0", i, bus.valid_out); end
            if (bus.ack_out !== 1'b1) begin bad++; $display("FAIL idle_ack[%0d] got=%b want=1", i, bus.ack_out); end
            step();
        end
    endtask

    task automatic test_bypass();
        for (int i = 0; i < 2; i++) begin
            drive(i == 0, 3'd5, 1'b1);
            total += 3;
            if (bus.valid_out !== m_valid()) begin bad++; $display("FAIL bypass_valid[%0d] got=%b want=%b", i, bus.valid_out, m_valid()); end
            if (m_valid() && bus.data_out !== 3'd5) begin bad++; $display("FAIL bypass_data[%0d] got=%0d want=5", i, bus.data_out); end
            if (bus.ack_out !== 1'b1) begin bad++; $display("FAIL bypass_ack[%0d] got=%b want=1", i, bus.ack_out); end
            step();
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 3'd6, 1'b0);
        step();
        drive(1'b1, 3'd7, 1'b0);
        step();
        drive(1'b0, 3'd0, 1'b1);
        total++;
        if (bus.ack_out !== 1'b0) begin bad++; $display("FAIL rmid_full_ack got=%b want=0", bus.ack_out); end
        rst = 1'b1;
        step();
        drive(1'b0, 3'd0, 1'b1);
        total += 2;
        if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", bus.valid_out); end
        if (bus.ack_out !== 1'b0) begin bad++; $display("FAIL rmid_ack got=%b want=0", bus.ack_out); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            drive(1'b0, 3'd0, 1'b1);
            total++;
            if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL rmid_replay[%0d] got=%b want=0", i, bus.valid_out); end
        end
        step();
    endtask

    task automatic test_random();
        bit           cur_v = 1'b0;
        logic [W-1:0] cur_d = '0;
        bit           acc;
        for (int i = 0; i < 400; i++) begin
            // Producer keeps an unaccepted beat stable until acked.
            if (!cur_v || acc) begin
                cur_v = ($urandom_range(0, 3) != 0);
                cur_d = W'($urandom);
            end
            drive(cur_v, cur_d, $urandom_range(0, 2) != 0);
            total += 3;
            if (bus.ack_out !== m_ack()) begin bad++; $display("FAIL rand_ack[%0d] got=%b want=%b", i, bus.ack_out, m_ack()); end
            if (bus.valid_out !== m_valid()) begin bad++; $display("FAIL rand_valid[%0d] got=%b want=%b", i, bus.valid_out, m_valid()); end
            if (m_valid() && bus.data_out !== m_data()) begin bad++; $display("FAIL rand_data[%0d] got=%0d want=%0d", i, bus.data_out, m_data()); end
            acc = cur_v && m_ack();
            step();
        end
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.ack_in   = 1'b0;
        test_reset();
        test_stall();
        test_drain();
        test_stream();
        test_idle();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
